series_evaluator: RTL
=====================

// Module: series_evaluator
// PURPOSE
//   Sequential consumer of the 16x16 coefficient ROM. Evaluates the even-power
//   series  S = sum t_k,  t_0 = 1.0,  t_{k+1} = t_k * u * c_k.
//   u is the Q.10 operand and c_k = ROM[k], a signed Q.10 factor (c_0 = -1.0).
//   With u = y^2/2 the result is cos(y). Feeds the horizontal-distance datapath.
//   Drives rom_addr and reads rom_data combinationally in the same cycle.
// PARAMETERS
//   N_TERMS   7    number of ROM factors applied (1..16)
//   FRAC      10   fractional bits of all Q-format values (1.0 = 1024)
//   ACC_W     20   internal accumulator width, signed
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request; sampled only while busy=0
//   operand_in in   16  u, signed Q6.10; latched on an accepted start
//   rom_addr   out  4   coefficient index k to ROM
//   rom_data   in   16  c_k from ROM, signed Q.10, combinational
//   busy       out  1   high from the cycle after accept until done
//   done       out  1   one-cycle pulse: result valid
//   result     out  16  S, signed Q.10, saturated; holds until next done
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE. busy=0, done=0, result=0, rom_addr=0.
//     Internal term, acc, u regs = 0. Reset mid-operation aborts without a done pulse.
//   - FSM IDLE -> MUL_U -> MUL_C -> (MUL_U | FIN) -> IDLE.
//   - IDLE: on start=1, latch u=operand_in, term=1024, acc=1024, k=0; go MUL_U.
//     start is ignored while busy=1; there is no queueing.
//   - MUL_U: tmp = sat16((term*u) >>> FRAC).
//   - MUL_C: term = sat16((tmp*rom_data) >>> FRAC); acc = acc + term.
//     Then k=k+1. If k+1 == N_TERMS or rom_data == 0, go FIN; otherwise go MUL_U.
//   - rom_addr = k at all times; it must be stable during MUL_C.
//   - FIN: result = sat16(acc), done=1 for this cycle; busy=0 next cycle.
//   - Arithmetic: products are 32-bit signed. >>> is arithmetic (floor).
//     sat16 clamps to [-32768, 32767]. acc is ACC_W bits and does not wrap
//     for |u| < 32.
//   - Latency with N_TERMS=7 and no early stop: start edge E0, done high in
//     the cycle after edge E15 (1 + 2*N_TERMS + 1 edges). busy is high
//     during E1..E15.
//   - A new start may be given in the same cycle done is high. It is accepted
//     at the next edge because FSM is IDLE then (back-to-back throughput:
//     one evaluation per 16 cycles).
//   - rom_data == 0 stops early. This is also the response to addresses 7..15
//     if N_TERMS > 7.
// TESTING
//   1. u=0, start -> every term after t_0 is 0; result=1024, done at E15.
//   2. u=1024 (1.0) -> acc steps 1024,0,170,158,158,...; result=158.
//   3. u=512 (0.5) -> acc steps 1024,512,554,552,552,...; result=552.
//   4. start held high through a run -> exactly one done per 16 cycles, and
//      operand_in changes mid-run have no effect.
//   5. rst_n low at MUL_C of term 3 -> immediately busy=0, done=0, result=0.
//      A restart with u=1024 then gives 158.
//   6. u=-32768 -> term1 saturates to 32767, no X/wrap; result clamps to 32767.

Source files
------------

// File: rtl/series_evaluator_if.sv
// Handshake, operand/result and coefficient-ROM signals of series_evaluator.
// The master side is the requester, which also owns the coefficient ROM and
// answers rom_addr combinationally on rom_data.
interface series_evaluator_if;
  logic        start;
  logic [15:0] operand_in;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport master (
    output start,
    output operand_in,
    output rom_data,
    input  rom_addr,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  operand_in,
    input  rom_data,
    output rom_addr,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/series_evaluator.sv
// Sequential even-power series evaluator:
//   S = sum t_k,  t_0 = 1.0,  t_{k+1} = t_k * u * c_k,  c_k = ROM[k].
// With u = y^2/2 and the cosine factor ROM the result is cos(y).
// One multiply per state: MUL_U forms t_k*u, MUL_C applies c_k and
// accumulates. A zero coefficient ends the series early.
module series_evaluator #(
  parameter int N_TERMS = 7,
  parameter int FRAC    = 10,
  parameter int ACC_W   = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  series_evaluator_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL_U = 2'd1;
  localparam logic [1:0] S_MUL_C = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic signed [15:0] ONE = 16'(1 << FRAC);

  logic [1:0]               state_q, state_d;
  logic signed [15:0]       u_q, u_d;
  logic signed [15:0]       term_q, term_d;
  logic signed [15:0]       tmp_q, tmp_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]               k_q, k_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic signed [15:0]       result_q, result_d;

  logic signed [15:0]       coef;
  logic signed [31:0]       prod_u, prod_c;
  logic signed [15:0]       tmp_new, term_new;
  logic signed [31:0]       acc_ext;
  logic [4:0]               k_next;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  assign coef     = bus.rom_data;
  assign prod_u   = 32'(term_q) * 32'(u_q);
  assign prod_c   = 32'(tmp_q) * 32'(coef);
  assign tmp_new  = sat16(prod_u >>> FRAC);
  assign term_new = sat16(prod_c >>> FRAC);
  assign acc_ext  = 32'(acc_q);
  assign k_next   = {1'b0, k_q} + 5'd1;

  // Next-state and datapath update for the evaluation sequence.
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    term_d   = term_q;
    tmp_d    = tmp_q;
    acc_d    = acc_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          u_d     = bus.operand_in;
          term_d  = ONE;
          acc_d   = ACC_W'(ONE);
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_MUL_U;
        end
      end
      S_MUL_U: begin
        tmp_d   = tmp_new;
        state_d = S_MUL_C;
      end
      S_MUL_C: begin
        term_d = term_new;
        acc_d  = acc_q + ACC_W'(term_new);
        k_d    = k_q + 4'd1;
        if ((k_next == 5'(N_TERMS)) || (bus.rom_data == '0))
          state_d = S_FIN;
        else
          state_d = S_MUL_U;
      end
      S_FIN: begin
        result_d = sat16(acc_ext);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any evaluation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      u_q      <= '0;
      term_q   <= '0;
      tmp_q    <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      term_q   <= term_d;
      tmp_q    <= tmp_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.rom_addr = k_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule
